// File: rtl/afifo_wptr_full.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : afifo_wptr_full
// Description : Write-side pointer, Gray pointer, full / level / overflow flags
//               of an asynchronous FIFO, entirely in the write clock domain.
//               Optional almost-full flag guarded by macro AFIFO_ALMOST_FULL_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module afifo_wptr_full #(
    parameter int ADDR_WIDTH            = 4,
    parameter int ALMOST_FULL_THRESHOLD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH:0]   rptr_gray_sync_i,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic                  wr_accept_o,
    output logic [ADDR_WIDTH:0]   wptr_gray_o,
    output logic                  full_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  overflow_o,
    output logic                  almost_full_o
);

    // Elaboration-time sanity checks on the configuration.
    if (ADDR_WIDTH < 2) begin : g_addr_width_check
        $error("afifo_wptr_full: ADDR_WIDTH must be >= 2");
    end
    if (ALMOST_FULL_THRESHOLD < 0) begin : g_threshold_check
        $error("afifo_wptr_full: ALMOST_FULL_THRESHOLD must be >= 0");
    end

    logic [ADDR_WIDTH:0] r_wbin;
    logic [ADDR_WIDTH:0] r_wgray;
    logic                r_full;
    logic [ADDR_WIDTH:0] r_level;
    logic                r_overflow;

    logic                w_accept;
    logic [ADDR_WIDTH:0] w_wbin_next;
    logic [ADDR_WIDTH:0] w_wgray_next;
    logic [ADDR_WIDTH:0] w_rptr_full_cmp;
    logic [ADDR_WIDTH:0] w_rbin;
    logic [ADDR_WIDTH:0] w_level_next;
    logic                w_full_next;

    // The accept decision uses the registered full flag, so a write arriving in
    // the same cycle the read pointer frees a slot is still rejected.
    assign w_accept     = wr_en_i & ~r_full;
    assign w_wbin_next  = r_wbin + (ADDR_WIDTH+1)'(w_accept);
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

    // Full when the write pointer is exactly one lap ahead: top two Gray bits
    // inverted, remaining bits equal.
    assign w_rptr_full_cmp = {~rptr_gray_sync_i[ADDR_WIDTH:ADDR_WIDTH-1],
                              rptr_gray_sync_i[ADDR_WIDTH-2:0]};
    assign w_full_next     = (w_wgray_next == w_rptr_full_cmp);

    // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
    for (genvar i = 0; i <= ADDR_WIDTH; i++) begin : g_gray2bin
        assign w_rbin[i] = ^(rptr_gray_sync_i >> i);
    end

    assign w_level_next = w_wbin_next - w_rbin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wbin     <= '0;
            r_wgray    <= '0;
            r_full     <= 1'b0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wbin     <= w_wbin_next;
            r_wgray    <= w_wgray_next;
            r_full     <= w_full_next;
            r_level    <= w_level_next;
            r_overflow <= r_overflow | (wr_en_i & r_full);
        end
    end

`ifdef AFIFO_ALMOST_FULL_EN
    localparam logic [ADDR_WIDTH+1:0] c_DEPTH = (ADDR_WIDTH+2)'(2**ADDR_WIDTH);
    // Thresholds beyond the depth simply mean "always almost full".
    localparam logic [ADDR_WIDTH+1:0] c_AF_THRESH =
        (ALMOST_FULL_THRESHOLD >= 2**ADDR_WIDTH) ? c_DEPTH
                                                 : (ADDR_WIDTH+2)'(ALMOST_FULL_THRESHOLD);

    logic                  r_almost_full;
    logic [ADDR_WIDTH+1:0] w_free_next;

    assign w_free_next = c_DEPTH - {1'b0, w_level_next};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_free_next <= c_AF_THRESH);
        end
    end

    assign almost_full_o = r_almost_full;
`else
    assign almost_full_o = 1'b0;
`endif

    assign waddr_o     = r_wbin[ADDR_WIDTH-1:0];
    assign wr_accept_o = w_accept;
    assign wptr_gray_o = r_wgray;
    assign full_o      = r_full;
    assign level_o     = r_level;
    assign overflow_o  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_afifo_wptr_full.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_afifo_wptr_full
// Description : Self-checking bench for afifo_wptr_full (ADDR_WIDTH=4) against a
//               counter-based occupancy model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_afifo_wptr_full;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en_i;
    logic [4:0] rptr_gray_sync_i;
    logic [3:0] waddr_o;
    logic       wr_accept_o;
    logic [4:0] wptr_gray_o;
    logic       full_o;
    logic [4:0] level_o;
    logic       overflow_o;
    logic       almost_full_o;

    int checks   = 0;
    int failures = 0;

    // Model: total accepted writes and total reads seen, as plain counters.
    int m_wcnt, m_rcnt, m_level;
    bit m_full, m_ovf, m_af;
    bit exp_accept, obs_accept;

    always #5 clk = ~clk;

    afifo_wptr_full #(.ADDR_WIDTH(4), .ALMOST_FULL_THRESHOLD(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_en_i         (wr_en_i),
        .rptr_gray_sync_i(rptr_gray_sync_i),
        .waddr_o         (waddr_o),
        .wr_accept_o     (wr_accept_o),
        .wptr_gray_o     (wptr_gray_o),
        .full_o          (full_o),
        .level_o         (level_o),
        .overflow_o      (overflow_o),
        .almost_full_o   (almost_full_o)
    );

    function automatic logic [4:0] to_gray(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    function automatic bit af_rule(input int level);
`ifdef AFIFO_ALMOST_FULL_EN
        return (16 - level) <= 2;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive_reset(input bit wen);
        @(negedge clk);
        reset = 1'b1; wr_en_i = wen; rptr_gray_sync_i = '0;
        @(posedge clk); #1;
        m_wcnt = 0; m_rcnt = 0; m_level = 0; m_full = 0; m_ovf = 0; m_af = 0;
    endtask

    // One write-clock cycle; rcnt is the total read count the read side reports.
    task automatic drive_cycle(input bit wen, input int rcnt);
        @(negedge clk);
        reset = 1'b0; wr_en_i = wen; rptr_gray_sync_i = to_gray(rcnt);
        #1;
        obs_accept = wr_accept_o;
        exp_accept = wen && !m_full;
        @(posedge clk); #1;
        if (wen && m_full) m_ovf = 1;
        if (exp_accept) m_wcnt++;
        m_rcnt  = rcnt;
        m_level = (m_wcnt - m_rcnt) & 31;
        m_full  = (m_level == 16);
        m_af    = af_rule(m_level);
    endtask

    task automatic test_reset();
        drive_reset(1'b1);
        drive_reset(1'b1);
        checks++;
        if ({waddr_o, wptr_gray_o, full_o, level_o, overflow_o, almost_full_o} !== 17'd0) begin
            failures++;
            $display("FAIL reset_state: got waddr=%0d gray=%b full=%b level=%0d ovf=%b af=%b, want all 0",
                     waddr_o, wptr_gray_o, full_o, level_o, overflow_o, almost_full_o);
        end
        drive_cycle(1'b1, 0);
        checks++;
        if (obs_accept !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_accept: got %b want 1", obs_accept);
        end
    endtask

    task automatic test_fill();
        drive_reset(1'b0);
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, 0);
            checks++;
            if (obs_accept !== exp_accept || level_o !== 5'(m_level) || full_o !== m_full) begin
                failures++;
                $display("FAIL fill_step%0d: got acc=%b level=%0d full=%b want acc=%b level=%0d full=%b",
                         i, obs_accept, level_o, full_o, exp_accept, m_level, m_full);
            end
        end
        checks++;
        if (full_o !== 1'b1 || level_o !== 5'd16 || wptr_gray_o !== 5'b11000 || waddr_o !== 4'd0) begin
            failures++;
            $display("FAIL fill_full: got full=%b level=%0d gray=%b waddr=%0d want 1 16 11000 0",
                     full_o, level_o, wptr_gray_o, waddr_o);
        end
    endtask

    task automatic test_overflow();
        drive_cycle(1'b1, 0);
        checks++;
        if (obs_accept !== 1'b0 || wptr_gray_o !== 5'b11000 || overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL overflow_write: got acc=%b gray=%b ovf=%b want 0 11000 1",
                     obs_accept, wptr_gray_o, overflow_o);
        end
    endtask

    task automatic test_read_release();
        drive_cycle(1'b0, 1);
        checks++;
        if (full_o !== 1'b0 || level_o !== 5'd15 || overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL read_release: got full=%b level=%0d ovf=%b want 0 15 1",
                     full_o, level_o, overflow_o);
        end
        drive_cycle(1'b1, 1);
        checks++;
        if (obs_accept !== 1'b1 || full_o !== 1'b1 || level_o !== 5'd16) begin
            failures++;
            $display("FAIL refill: got acc=%b full=%b level=%0d want 1 1 16", obs_accept, full_o, level_o);
        end
        // Write while full, with the read pointer advancing the same cycle.
        drive_cycle(1'b1, 2);
        checks++;
        if (obs_accept !== 1'b0 || full_o !== 1'b0 || level_o !== 5'd15) begin
            failures++;
            $display("FAIL write_while_read: got acc=%b full=%b level=%0d want 0 0 15",
                     obs_accept, full_o, level_o);
        end
    endtask

    task automatic test_wrap();
        bit seen_msb = 0, back_to_zero = 0, saw_full = 0, addr_wrap = 0;
        logic [3:0] prev_addr;
        drive_reset(1'b0);
        prev_addr = waddr_o;
        for (int i = 0; i < 32; i++) begin
            drive_cycle(1'b1, m_wcnt);
            if (wptr_gray_o === 5'b10000) seen_msb = 1;
            if (seen_msb && wptr_gray_o === 5'b00000) back_to_zero = 1;
            if (full_o) saw_full = 1;
            if (prev_addr === 4'd15 && waddr_o === 4'd0) addr_wrap = 1;
            prev_addr = waddr_o;
            checks++;
            if (wptr_gray_o !== to_gray(m_wcnt) || waddr_o !== 4'(m_wcnt)) begin
                failures++;
                $display("FAIL wrap_step%0d: got gray=%b waddr=%0d want gray=%b waddr=%0d",
                         i, wptr_gray_o, waddr_o, to_gray(m_wcnt), m_wcnt & 15);
            end
        end
        checks++;
        if (!(seen_msb && back_to_zero && addr_wrap) || saw_full || m_wcnt != 32) begin
            failures++;
            $display("FAIL wrap_summary: got msb=%b zero=%b addrwrap=%b full_seen=%b accepts=%0d want 1 1 1 0 32",
                     seen_msb, back_to_zero, addr_wrap, saw_full, m_wcnt);
        end
    endtask

    task automatic test_almost_full();
        drive_reset(1'b0);
        for (int i = 0; i < 13; i++) drive_cycle(1'b1, 0);
        checks++;
        if (level_o !== 5'd13 || almost_full_o !== af_rule(13)) begin
            failures++;
            $display("FAIL almost_full_13: got level=%0d af=%b want 13 %b", level_o, almost_full_o, af_rule(13));
        end
        drive_cycle(1'b1, 0);
        checks++;
        if (level_o !== 5'd14 || almost_full_o !== af_rule(14)) begin
            failures++;
            $display("FAIL almost_full_14: got level=%0d af=%b want 14 %b", level_o, almost_full_o, af_rule(14));
        end
    endtask

    task automatic test_random();
        int rc;
        drive_reset(1'b0);
        for (int i = 0; i < 400; i++) begin
            rc = m_rcnt;
            if (rc < m_wcnt && $urandom_range(0, 2) != 0) rc = rc + 1;
            drive_cycle(1'($urandom_range(0, 3) != 0), rc);
            checks++;
            if (obs_accept !== exp_accept || wptr_gray_o !== to_gray(m_wcnt) || waddr_o !== 4'(m_wcnt) ||
                full_o !== m_full || level_o !== 5'(m_level) || overflow_o !== m_ovf ||
                almost_full_o !== m_af) begin
                failures++;
                $display("FAIL random_cycle%0d: got acc=%b gray=%b waddr=%0d full=%b level=%0d ovf=%b af=%b want %b %b %0d %b %0d %b %b",
                         i, obs_accept, wptr_gray_o, waddr_o, full_o, level_o, overflow_o, almost_full_o,
                         exp_accept, to_gray(m_wcnt), m_wcnt & 15, m_full, m_level, m_ovf, m_af);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, m_rcnt);
        drive_reset(1'b1);
        checks++;
        if ({waddr_o, wptr_gray_o, full_o, level_o, overflow_o, almost_full_o} !== 17'd0) begin
            failures++;
            $display("FAIL reset_mid: got waddr=%0d gray=%b full=%b level=%0d ovf=%b af=%b, want all 0",
                     waddr_o, wptr_gray_o, full_o, level_o, overflow_o, almost_full_o);
        end
    endtask

    initial begin
        reset = 1'b1; wr_en_i = 1'b0; rptr_gray_sync_i = '0;
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_wrap();
        test_almost_full();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
